// File: rtl/output_module.sv
// Transmit side of a router port: round-robin arbitration of input-port head flits into a
// small output FIFO sent downstream under valid/full. `OUTPUT_STATS_EN adds flit/stall counters.
`timescale 1ns/1ps
module output_module #(
  parameter int unsigned MSB_SLOT  = 5,
  parameter int unsigned DSIZE     = 1 << MSB_SLOT,
  parameter int unsigned OBUF_ADDR = 2,
  parameter logic [2:0]  PORT      = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         req,
  input  logic [5*DSIZE-1:0] data_in,
  output logic [4:0]         grant,
  output logic [DSIZE-1:0]   data_out,
  output logic               out_valid,
  input  logic               recv_full
`ifdef OUTPUT_STATS_EN
  ,
  output logic [15:0]        flit_count,
  output logic [15:0]        stall_count
`endif
);

  localparam int unsigned Depth = 1 << OBUF_ADDR;

  logic [OBUF_ADDR:0]   count_q, count_d;
  logic [OBUF_ADDR-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]           rr_ptr_q;
  logic [DSIZE-1:0]     storage_q [Depth];

  logic [4:0] mreq;
  logic [2:0] grant_idx;
  logic [3:0] cand;
  logic       push, pop, full;

  // No U-turn: a flit never returns through the port it arrived on.
  always_comb begin
    mreq       = req;
    mreq[PORT] = 1'b0;
  end

  // count never exceeds Depth, so its MSB alone flags a full FIFO.
  assign full = count_q[OBUF_ADDR];

  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    if (!reset && !full) begin
      for (int k = 1; k <= 5; k++) begin
        cand = {1'b0, rr_ptr_q} + 4'(k);
        if (cand >= 4'd5) cand = cand - 4'd5;
        if (grant == 5'b0 && mreq[cand[2:0]]) begin
          grant[cand[2:0]] = 1'b1;
          grant_idx        = cand[2:0];
        end
      end
    end
  end

  assign push      = |grant;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && !recv_full;
  assign data_out  = out_valid ? storage_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= 3'd4;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rr_ptr_q <= grant_idx;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q] <= data_in[grant_idx*DSIZE +: DSIZE];
  end

`ifdef OUTPUT_STATS_EN
  logic [15:0] flit_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop) flit_count_q <= flit_count_q + 16'd1;
      if (out_valid && recv_full) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign flit_count  = flit_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
